// File: rtl/z80_m1_trace.sv
// z80_m1_trace: observes tv80 M1 opcode fetches, groups prefix bytes with
// their opcode, measures clocks per instruction and queues one record per
// retired instruction in a small first-word-fall-through FIFO.
//
// Optional build macro: TRACE_TSTATE_EN
//   defined     -> per-instruction clock counter is built, o_tstates carries it
//   not defined -> no counter, no FIFO field for it, o_tstates reads 8'h00
module z80_m1_trace #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_m1_n,
    input  logic          i_mreq_n,
    input  logic          i_rd_n,
    input  logic [15:0]   i_addr,
    input  logic [7:0]    i_di,
    input  logic          i_ready,
    input  logic          i_clr,
    output logic          o_valid,
    output logic [15:0]   o_pc,
    output logic [7:0]    o_prefix,
    output logic [7:0]    o_opcode,
    output logic [7:0]    o_tstates,
    output logic          o_overflow,
    output logic [CW-1:0] o_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [7:0] B_CB = 8'hCB;
    localparam logic [7:0] B_DD = 8'hDD;
    localparam logic [7:0] B_ED = 8'hED;
    localparam logic [7:0] B_FD = 8'hFD;

    typedef enum logic [2:0] {
        S_IDLE,
        S_IXY,
        S_CBX,
        S_EDX,
        S_DONE
    } state_t;

    // ------------------------------------------------------------------
    // Fetch detection
    // ------------------------------------------------------------------
    logic       fetch;
    logic       fetch_q;
    logic       fetch_start;
    logic       fetch_end;
    logic [7:0] lat;

    assign fetch       = ~i_m1_n & ~i_mreq_n & ~i_rd_n;
    assign fetch_start = fetch & ~fetch_q;
    assign fetch_end   = ~fetch & fetch_q;

    // Remember last clock's fetch condition and the byte seen while fetching
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            fetch_q <= 1'b0;
            lat     <= 8'h00;
        end else begin
            fetch_q <= fetch;
            if (fetch) begin
                lat <= i_di;
            end
        end
    end

    // ------------------------------------------------------------------
    // Instruction grouping FSM
    // ------------------------------------------------------------------
    state_t      state;
    state_t      state_d;
    logic [15:0] pc;
    logic [15:0] pc_d;
    logic [7:0]  pfx;
    logic [7:0]  pfx_d;
    logic [7:0]  op;
    logic [7:0]  op_d;
    logic        push;

`ifdef TRACE_TSTATE_EN
    logic [7:0]  cnt;
    logic [7:0]  cnt_d;
`endif

    // Next-state: a new fetch in DONE retires the previous instruction,
    // fetch ends classify the byte as prefix or opcode
    always_comb begin
        state_d = state;
        pc_d    = pc;
        pfx_d   = pfx;
        op_d    = op;
        push    = 1'b0;

        if (fetch_start) begin
            case (state)
                S_IDLE: begin
                    pc_d = i_addr;
                end
                S_DONE: begin
                    push    = 1'b1;
                    pc_d    = i_addr;
                    state_d = S_IDLE;
                end
                default: begin
                end
            endcase
        end

        if (fetch_end) begin
            case (state)
                S_IDLE: begin
                    if (lat == B_DD || lat == B_FD) begin
                        pfx_d   = lat;
                        state_d = S_IXY;
                    end else if (lat == B_CB) begin
                        pfx_d   = B_CB;
                        state_d = S_CBX;
                    end else if (lat == B_ED) begin
                        pfx_d   = B_ED;
                        state_d = S_EDX;
                    end else begin
                        pfx_d   = 8'h00;
                        op_d    = lat;
                        state_d = S_DONE;
                    end
                end
                S_IXY: begin
                    if (lat == B_DD || lat == B_FD) begin
                        pfx_d = lat;
                    end else begin
                        op_d    = lat;
                        state_d = S_DONE;
                    end
                end
                S_CBX, S_EDX: begin
                    op_d    = lat;
                    state_d = S_DONE;
                end
                default: begin
                end
            endcase
        end
    end

`ifdef TRACE_TSTATE_EN
    // Clock counter: restarts at 1 on a new instruction, then counts every
    // clock while an instruction is open or a fetch is under way
    always_comb begin
        cnt_d = cnt;
        if (fetch_start && (state == S_IDLE || state == S_DONE)) begin
            cnt_d = 8'd1;
        end else if ((state != S_IDLE || fetch || fetch_q) && cnt != 8'd255) begin
            cnt_d = cnt + 8'd1;
        end
    end
`endif

    // State and instruction fields register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= S_IDLE;
            pc    <= 16'h0000;
            pfx   <= 8'h00;
            op    <= 8'h00;
`ifdef TRACE_TSTATE_EN
            cnt   <= 8'h00;
`endif
        end else begin
            state <= state_d;
            pc    <= pc_d;
            pfx   <= pfx_d;
            op    <= op_d;
`ifdef TRACE_TSTATE_EN
            cnt   <= cnt_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Record FIFO (first-word-fall-through)
    // ------------------------------------------------------------------
    logic [15:0]   mem_pc  [DEPTH];
    logic [7:0]    mem_pfx [DEPTH];
    logic [7:0]    mem_op  [DEPTH];
`ifdef TRACE_TSTATE_EN
    logic [7:0]    mem_ts  [DEPTH];
`endif
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          overflow;
    logic          full;
    logic          valid;
    logic          pop;
    logic          wr_en;

    assign full  = (count == CW'(DEPTH));
    assign valid = (count != '0);
    assign pop   = valid & i_ready;
    assign wr_en = push & (~full | pop);

    // Storage array; contents only matter where count says an entry is live
    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            mem_pc[wr_ptr]  <= pc;
            mem_pfx[wr_ptr] <= pfx;
            mem_op[wr_ptr]  <= op;
`ifdef TRACE_TSTATE_EN
            mem_ts[wr_ptr]  <= cnt;
`endif
        end
    end

    // Pointers, occupancy and the sticky drop flag (a drop beats a clear)
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (wr_en && !pop) begin
                count <= count + CW'(1);
            end else if (!wr_en && pop) begin
                count <= count - CW'(1);
            end
            if (push && full && !pop) begin
                overflow <= 1'b1;
            end else if (i_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    assign o_valid    = valid;
    assign o_count    = count;
    assign o_overflow = overflow;
    assign o_pc       = valid ? mem_pc[rd_ptr]  : 16'h0000;
    assign o_prefix   = valid ? mem_pfx[rd_ptr] : 8'h00;
    assign o_opcode   = valid ? mem_op[rd_ptr]  : 8'h00;
`ifdef TRACE_TSTATE_EN
    assign o_tstates  = valid ? mem_ts[rd_ptr]  : 8'h00;
`else
    assign o_tstates  = 8'h00;
`endif

endmodule
